// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: FSM state
// encodings, mux select constants and the select-to-grant decode.
package mux4_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETTLE = 2'd1,
        ARB_GRANT  = 2'd2
    } arb_state_t;

    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;
    localparam logic [1:0] SEL_I3 = 2'b11;

    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin pick: first set request bit scanning last+1,
// last+2, ... modulo 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       any
);
    // rot[gi] is the request that sits gi+1 places after the last served one
    logic [3:0] rot;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [1:0] OFF = 2'(gi + 1);
            logic [1:0] src;
            assign src     = last + OFF;
            assign rot[gi] = req[src];
        end
    endgenerate

    logic [1:0] off;

    always_comb begin
        off = 2'd3;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
    end

    assign pick = last + 2'd1 + off;
    assign any  = |req;
endmodule

// File: rtl/mux_4to1.sv
// Behavioural stand-in for the switch-level 4-to-1 mux: {s0,s1} selects i0..i3.
module mux_4to1 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic s0,
    input  logic s1,
    output logic out
);
    assign out = s0 ? (s1 ? i3 : i2) : (s1 ? i1 : i0);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the mux select and a one-hot grant, with a
// SETTLE cycle so gnt is always low around every select change.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy
);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    arb_state_t       state_reg;
    logic [1:0]       idx_reg;
    logic [1:0]       last_reg;
    logic [1:0]       sel_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       gnt_reg;
    logic             busy_reg;

    logic [1:0] pick;
    logic       any;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_reg),
        .pick (pick),
        .any  (any)
    );

    logic owner_req;
    logic contested;
    logic hold_done;

    assign owner_req = req[idx_reg];
    assign contested = |(req & ~sel_onehot(idx_reg));
    assign hold_done = (cnt_reg == HOLD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARB_IDLE;
            idx_reg   <= SEL_I0;
            last_reg  <= SEL_I3;
            sel_reg   <= SEL_I0;
            cnt_reg   <= '0;
            gnt_reg   <= 4'b0000;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (any) begin
                        idx_reg   <= pick;
                        sel_reg   <= pick;
                        busy_reg  <= 1'b1;
                        state_reg <= ARB_SETTLE;
                    end
                end
                ARB_SETTLE: begin
                    if (owner_req) begin
                        gnt_reg   <= sel_onehot(idx_reg);
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= ARB_GRANT;
                    end else begin
                        // A requester that vanished during SETTLE still counts as served
                        last_reg  <= idx_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= ARB_IDLE;
                    end
                end
                ARB_GRANT: begin
                    if (!owner_req || (hold_done && contested)) begin
                        gnt_reg   <= 4'b0000;
                        last_reg  <= idx_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= ARB_IDLE;
                    end else if (!hold_done) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    gnt_reg   <= 4'b0000;
                    busy_reg  <= 1'b0;
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign gnt  = gnt_reg;
    assign s0   = sel_reg[1];
    assign s1   = sel_reg[0];
    assign busy = busy_reg;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter feeding mux_4to1: cycle-by-cycle reference model
// plus directed scenarios with hand-computed grant order and timing.
module tb_mux4_rr_arbiter;
    localparam int MAXH = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] d     = 4'b0000;
    logic [3:0] gnt;
    logic       s0, s1, busy, out;

    int n_cmp = 0;
    int n_err = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .s0    (s0),
        .s1    (s1),
        .busy  (busy)
    );

    mux_4to1 u_mux (
        .i0  (d[0]),
        .i1  (d[1]),
        .i2  (d[2]),
        .i3  (d[3]),
        .s0  (s0),
        .s1  (s1),
        .out (out)
    );

    always #5 clk = ~clk;
    always @(negedge clk) d = 4'($urandom);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 select settling, 2 granted.
    int m_phase = 0;
    int m_owner = 0;
    int m_last  = 3;
    int m_held  = 0;
    int m_sel   = 0;

    function automatic int rr_next(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int k = 0; k < 4; k++)
            if (g[k]) return k;
        return -1;
    endfunction

    // Observed grant runs: owner, run length and preceding zero-gap
    int log_owner[$];
    int log_len[$];
    int log_gap[$];
    int run = 0;
    int gap = 0;

    function automatic int own_at(input int i);
        return (i < log_owner.size()) ? log_owner[i] : -1;
    endfunction
    function automatic int len_at(input int i);
        return (i < log_len.size()) ? log_len[i] : -1;
    endfunction
    function automatic int gap_at(input int i);
        return (i < log_gap.size()) ? log_gap[i] : -1;
    endfunction

    task automatic clear_log();
        log_owner.delete();
        log_len.delete();
        log_gap.delete();
    endtask

    always @(posedge clk) begin
        logic [31:0] exp_gnt;
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_last = 3; m_held = 0; m_sel = 0;
        end else begin
            case (m_phase)
                0: if (req != 4'b0000) begin
                    m_owner = rr_next(m_last, req);
                    m_sel   = m_owner;
                    m_phase = 1;
                end
                1: if (req[m_owner]) begin
                    m_phase = 2;
                    m_held  = 1;
                end else begin
                    m_last  = m_owner;
                    m_phase = 0;
                end
                default: begin
                    if (!req[m_owner] ||
                        (m_held >= MAXH && (req & ~(4'b0001 << m_owner)) != 4'b0000)) begin
                        m_last  = m_owner;
                        m_phase = 0;
                    end else begin
                        m_held++;
                    end
                end
            endcase
        end
        #1;
        exp_gnt = (m_phase == 2) ? (32'd1 << m_owner) : 32'd0;
        chk("gnt", gnt, exp_gnt);
        chk("sel", {s0, s1}, m_sel);
        chk("busy", busy, (m_phase != 0));
        if (gnt != 4'b0000) chk("datapath", out, d[m_owner]);

        if (!rst_n) begin
            run = 0;
            gap = 0;
        end else if (gnt != 4'b0000) begin
            if (run == 0) begin
                log_owner.push_back(onehot_idx(gnt));
                log_gap.push_back(gap);
            end
            run++;
            gap = 0;
        end else begin
            if (run != 0) log_len.push_back(run);
            run = 0;
            gap++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rot[5];
        int n2;
        exp_rot = '{0, 1, 2, 3, 0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", {s0, s1}, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // First pick after reset with req=1010: requester 1, then 3
        @(negedge clk);
        clear_log();
        req = 4'b1010;
        repeat (20) @(negedge clk);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        chk("first_pick", own_at(0), 1);
        chk("second_pick", own_at(1), 3);
        chk("first_len", len_at(0), MAXH);

        // Uncontested hold
        clear_log();
        req = 4'b0100;
        @(posedge clk); #1;
        chk("unc_sel", {s0, s1}, 2'b10);
        chk("unc_gnt_early", gnt, 4'b0000);
        @(posedge clk); #1;
        chk("unc_gnt", gnt, 4'b0100);
        repeat (18) @(posedge clk);
        @(negedge clk);
        chk("unc_still", gnt, 4'b0100);
        req = 4'b0000;
        @(posedge clk); #1;
        chk("unc_release", gnt, 4'b0000);
        repeat (3) @(negedge clk);
        chk("unc_len", len_at(0), 19);

        // Full rotation with everyone requesting
        do_reset();
        req = 4'b1111;
        repeat (32) @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) chk($sformatf("rot_owner%0d", i), own_at(i), exp_rot[i]);
        for (int i = 0; i < 4; i++) chk($sformatf("rot_len%0d", i), len_at(i), MAXH);
        for (int i = 1; i < 5; i++) chk($sformatf("rot_gap%0d", i), gap_at(i), 2);

        // req[2] drops during SETTLE: 2 counts as served, so 3 wins over 0
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        req = 4'b1001;
        repeat (2) @(posedge clk); #1;
        chk("drop_sel", {s0, s1}, 2'b11);
        chk("drop_gap_gnt", gnt, 4'b0000);
        @(posedge clk); #1;
        chk("drop_next_gnt", gnt, 4'b1000);
        repeat (3) @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        n2 = 0;
        foreach (log_owner[i]) if (log_owner[i] == 2) n2++;
        chk("drop_no_gnt2", n2, 0);
        chk("drop_first_owner", own_at(0), 3);

        // Owner drops on the same edge the hold limit is reached
        do_reset();
        req = 4'b0011;
        repeat (5) @(posedge clk);
        @(negedge clk);
        req = 4'b0010;
        repeat (8) @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("coinc_owner0", own_at(0), 0);
        chk("coinc_len0", len_at(0), MAXH);
        chk("coinc_owner1", own_at(1), 1);
        chk("coinc_gap1", gap_at(1), 2);
        chk("coinc_count", log_owner.size(), 2);

        // Asynchronous reset mid-grant
        clear_log();
        req = 4'b0100;
        repeat (3) @(negedge clk);
        chk("pre_rst_gnt", gnt, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", gnt, 4'b0000);
        chk("async_sel", {s0, s1}, 2'b00);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0001;
        @(posedge clk); #1;
        chk("post_rst_gnt1", gnt, 4'b0000);
        @(posedge clk); #1;
        chk("post_rst_gnt2", gnt, 4'b0001);
        @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
